// File: rtl/sdram_req_arbiter_if.sv
// Requester and SDRAM-controller signal bundle for sdram_req_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sdram_req_arbiter_if #(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16
);
    logic [NumPorts-1:0]           i_req;
    logic [NumPorts-1:0]           i_we;
    logic [NumPorts*AddrWidth-1:0] i_addr;
    logic [NumPorts*DataWidth-1:0] i_wdata;
    logic [NumPorts-1:0]           o_ack;
    logic [DataWidth-1:0]          o_rdata;
    logic                          o_timeout;
    logic                          o_busy;
    logic                          o_wr_req;
    logic                          o_rd_req;
    logic [AddrWidth-1:0]          o_wr_addr;
    logic [AddrWidth-1:0]          o_rd_addr;
    logic [DataWidth-1:0]          o_wr_data;
    logic [DataWidth-1:0]          i_rd_data;
    logic                          i_rd_rdy;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_rd_data, i_rd_rdy,
        output o_ack, o_rdata, o_timeout, o_busy,
        output o_wr_req, o_rd_req, o_wr_addr, o_rd_addr, o_wr_data
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_rd_data, i_rd_rdy,
        input  o_ack, o_rdata, o_timeout, o_busy,
        input  o_wr_req, o_rd_req, o_wr_addr, o_rd_addr, o_wr_data
    );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port.
// One transaction in flight; writes timed internally, reads end on rd_rdy or timeout.
module sdram_req_arbiter #(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int WrCycles  = 8,
    parameter int RdTimeout = 64
) (
    input  logic                i_sys_clk,
    input  logic                i_rst_n,
    sdram_req_arbiter_if.slave  bus
);
    localparam int PtrW   = $clog2(NumPorts);
    localparam int MaxCnt = (WrCycles > RdTimeout) ? WrCycles : RdTimeout;
    localparam int CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [PtrW-1:0]      rr_ptr;
    logic [PtrW-1:0]      pick;
    logic [PtrW-1:0]      gnt;
    logic                 found;
    logic [NumPorts-1:0]  req_eff;
    logic                 we_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] rdata_q;
    logic [CntW-1:0]      cnt;
    logic                 to_q;
    logic                 timeout_q;
    logic                 busy_q;
    logic                 wr_req_q;
    logic                 rd_req_q;
    logic [NumPorts-1:0]  ack_q;
    logic                 wr_last;
    logic                 rd_last;

    assign wr_last = (cnt == CntW'(WrCycles - 1));
    assign rd_last = (cnt == CntW'(RdTimeout - 1));

    // The port being acked still shows its old request this cycle.
    assign req_eff = bus.i_req & ~ack_q;

    always_comb begin
        int p;
        pick  = '0;
        found = 1'b0;
        p     = 0;
        for (int i = 0; i < NumPorts; i++) begin
            p = (int'(rr_ptr) + i) % NumPorts;
            if (!found && req_eff[PtrW'(p)]) begin
                found = 1'b1;
                pick  = PtrW'(p);
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? WAIT_WR : WAIT_RD;
            WAIT_WR: if (wr_last) state_nxt = DONE;
            WAIT_RD: if (bus.i_rd_rdy || rd_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr    <= '0;
            gnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            to_q      <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            ack_q     <= '0;
        end else begin
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= (state_nxt != IDLE);
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= pick;
                        we_q     <= bus.i_we[pick];
                        addr_q   <= bus.i_addr[int'(pick)*AddrWidth +: AddrWidth];
                        wdata_q  <= bus.i_wdata[int'(pick)*DataWidth +: DataWidth];
                        wr_req_q <= bus.i_we[pick];
                        rd_req_q <= ~bus.i_we[pick];
                        to_q     <= 1'b0;
                    end
                end
                ISSUE:   cnt <= '0;
                WAIT_WR: cnt <= cnt + 1'b1;
                WAIT_RD: begin
                    if (bus.i_rd_rdy) begin
                        rdata_q <= bus.i_rd_data;
                        to_q    <= 1'b0;
                    end else if (rd_last) begin
                        rdata_q <= '0;
                        to_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ack_q[gnt] <= 1'b1;
                    timeout_q  <= to_q;
                    rr_ptr     <= (gnt == PtrW'(NumPorts - 1)) ? '0 : gnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ack     = ack_q;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_wr_req  = wr_req_q;
    assign bus.o_rd_req  = rd_req_q;
    assign bus.o_wr_addr = addr_q;
    assign bus.o_rd_addr = addr_q;
    assign bus.o_wr_data = wdata_q;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter (4 ports, WrCycles=8, RdTimeout=64).
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_sdram_req_arbiter;
    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int WR = 8;
    localparam int TO = 64;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    sdram_req_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus();

    sdram_req_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
        .WrCycles(WR), .RdTimeout(TO)
    ) dut (
        .i_sys_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.i_req     = '0;
        bus.i_we      = '0;
        bus.i_addr    = '0;
        bus.i_wdata   = '0;
        bus.i_rd_data = '0;
        bus.i_rd_rdy  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_txn(input int p, input logic we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_req[p]          = 1'b1;
        bus.i_we[p]           = we;
        bus.i_addr[p*AW +: AW] = a;
        bus.i_wdata[p*DW +: DW] = d;
    endtask

    task automatic wait_issue(output int ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_wr_req || bus.o_rd_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    // n = falling edges from the request pulse to the ack; >200 means none.
    task automatic wait_ack(input int rdy_at, input bit stray, input logic [DW-1:0] rdat,
                            output int n, output int wp, output int rp);
        n = 0; wp = 0; rp = 0;
        while (n <= 200) begin
            @(negedge clk);
            n++;
            if (bus.o_wr_req) wp++;
            if (bus.o_rd_req) rp++;
            if (bus.o_ack != '0) break;
            bus.i_rd_rdy  = stray ? (n % 2 == 1) : (n == rdy_at);
            bus.i_rd_data = rdat;
        end
        bus.i_rd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (bus.o_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %h want 0", bus.o_ack); end
        n_chk++; if (bus.o_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.o_rdata); end
        n_chk++; if ({bus.o_timeout, bus.o_busy, bus.o_wr_req, bus.o_rd_req} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.o_timeout, bus.o_busy, bus.o_wr_req, bus.o_rd_req}); end
        n_chk++; if ({bus.o_wr_addr, bus.o_rd_addr, bus.o_wr_data} !== '0) begin
            n_fail++; $display("FAIL reset_addr_data: got %h %h %h want 0", bus.o_wr_addr, bus.o_rd_addr, bus.o_wr_data); end
    endtask

    task automatic test_write();
        int ok, n, wp, rp;
        start_txn(0, 1'b1, 22'h00012A, 16'h00C3);
        wait_issue(ok);
        n_chk++; if (ok !== 1) begin n_fail++; $display("FAIL wr_issue: got %0d want 1", ok); end
        n_chk++; if ({bus.o_wr_req, bus.o_rd_req, bus.o_busy} !== 3'b101) begin
            n_fail++; $display("FAIL wr_pulse: got %b want 101", {bus.o_wr_req, bus.o_rd_req, bus.o_busy}); end
        n_chk++; if (bus.o_wr_addr !== 22'h00012A || bus.o_rd_addr !== 22'h00012A) begin
            n_fail++; $display("FAIL wr_addr: got %h/%h want 00012a", bus.o_wr_addr, bus.o_rd_addr); end
        n_chk++; if (bus.o_wr_data !== 16'h00C3) begin n_fail++; $display("FAIL wr_data: got %h want 00c3", bus.o_wr_data); end
        start_txn(0, 1'b0, 22'h3F0000, 16'hFFFF);
        wait_ack(0, 1'b0, 16'h0, n, wp, rp);
        bus.i_req[0] = 1'b0;
        n_chk++; if (n !== WR + 2) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", n, WR + 2); end
        n_chk++; if (bus.o_ack !== 4'b0001) begin n_fail++; $display("FAIL wr_ack: got %b want 0001", bus.o_ack); end
        n_chk++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b want 0", bus.o_timeout); end
        n_chk++; if (wp !== 0 || rp !== 0) begin n_fail++; $display("FAIL wr_extra_pulse: got %0d/%0d want 0/0", wp, rp); end
        n_chk++; if (bus.o_wr_addr !== 22'h00012A || bus.o_wr_data !== 16'h00C3) begin
            n_fail++; $display("FAIL wr_latched: got %h/%h want 00012a/00c3", bus.o_wr_addr, bus.o_wr_data); end
    endtask

    task automatic test_read();
        int ok, n, wp, rp;
        start_txn(1, 1'b0, 22'h000005, 16'h0);
        wait_issue(ok);
        n_chk++; if ({ok[0], bus.o_rd_req, bus.o_wr_req} !== 3'b110) begin
            n_fail++; $display("FAIL rd_pulse: got %b want 110", {ok[0], bus.o_rd_req, bus.o_wr_req}); end
        n_chk++; if (bus.o_rd_addr !== 22'h000005) begin n_fail++; $display("FAIL rd_addr: got %h want 000005", bus.o_rd_addr); end
        wait_ack(5, 1'b0, 16'hBEEF, n, wp, rp);
        bus.i_req[1] = 1'b0;
        n_chk++; if (n !== 7) begin n_fail++; $display("FAIL rd_latency: got %0d want 7", n); end
        n_chk++; if (bus.o_ack !== 4'b0010) begin n_fail++; $display("FAIL rd_ack: got %b want 0010", bus.o_ack); end
        n_chk++; if (bus.o_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", bus.o_rdata); end
        n_chk++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL rd_timeout: got %b want 0", bus.o_timeout); end
    endtask

    task automatic test_timeout();
        int ok, n, wp, rp;
        start_txn(2, 1'b0, 22'h00ABCD, 16'h0);
        wait_issue(ok);
        wait_ack(0, 1'b0, 16'h0, n, wp, rp);
        bus.i_req[2] = 1'b0;
        n_chk++; if (n !== TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", n, TO + 2); end
        n_chk++; if (bus.o_ack !== 4'b0100) begin n_fail++; $display("FAIL to_ack: got %b want 0100", bus.o_ack); end
        n_chk++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", bus.o_timeout); end
        n_chk++; if (bus.o_rdata !== 16'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", bus.o_rdata); end
        @(negedge clk);
        n_chk++; if ({bus.o_timeout, bus.o_ack} !== 5'b0) begin
            n_fail++; $display("FAIL to_pulse_width: got %b want 00000", {bus.o_timeout, bus.o_ack}); end
        start_txn(3, 1'b0, 22'h001234, 16'h0);
        wait_issue(ok);
        wait_ack(TO, 1'b0, 16'h5A5A, n, wp, rp);
        bus.i_req[3] = 1'b0;
        n_chk++; if (n !== TO + 2) begin n_fail++; $display("FAIL last_latency: got %0d want %0d", n, TO + 2); end
        n_chk++; if (bus.o_ack !== 4'b1000) begin n_fail++; $display("FAIL last_ack: got %b want 1000", bus.o_ack); end
        n_chk++; if (bus.o_timeout !== 1'b0 || bus.o_rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL last_result: got %b/%h want 0/5a5a", bus.o_timeout, bus.o_rdata); end
    endtask

    task automatic test_stray();
        int ok, n, wp, rp;
        bus.i_rd_rdy  = 1'b1;
        bus.i_rd_data = 16'h1111;
        @(negedge clk);
        bus.i_rd_rdy = 1'b0;
        n_chk++; if ({bus.o_ack, bus.o_busy} !== 5'b0 || bus.o_rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL stray_idle: got %b/%h want 00000/5a5a", {bus.o_ack, bus.o_busy}, bus.o_rdata); end
        start_txn(0, 1'b1, 22'h000777, 16'h1234);
        wait_issue(ok);
        n_chk++; if ({ok[0], bus.o_wr_req, bus.o_wr_addr} !== {2'b11, 22'h000777}) begin
            n_fail++; $display("FAIL stray_issue: got %b/%h want 11/000777", {ok[0], bus.o_wr_req}, bus.o_wr_addr); end
        wait_ack(0, 1'b1, 16'h2222, n, wp, rp);
        bus.i_req[0] = 1'b0;
        n_chk++; if (n !== WR + 2 || bus.o_ack !== 4'b0001) begin
            n_fail++; $display("FAIL stray_wr_ack: got %0d/%b want %0d/0001", n, bus.o_ack, WR + 2); end
        n_chk++; if (bus.o_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL stray_rdata: got %h want 5a5a", bus.o_rdata); end
        n_chk++; if (wp !== 0 || rp !== 0) begin n_fail++; $display("FAIL stray_pulses: got %0d/%0d want 0/0", wp, rp); end
    endtask

    task automatic test_round_robin();
        int got[6];
        int exp_all[6]  = '{0, 1, 2, 3, 0, 1};
        int exp_skip[6] = '{0, 1, 3, 0, 1, 3};
        int k;
        for (int phase = 0; phase < 2; phase++) begin
            apply_reset();
            for (int p = 0; p < NP; p++)
                if (phase == 0 || p != 2) start_txn(p, 1'b1, 22'(32'h100 + p), 16'(p));
            for (int i = 0; i < 6; i++) got[i] = -1;
            k = 0;
            for (int c = 0; c < 300 && k < 6; c++) begin
                @(negedge clk);
                if (bus.o_wr_req) begin
                    got[k] = int'(bus.o_wr_addr) - 32'h100;
                    k++;
                end
            end
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (got[i] !== (phase == 0 ? exp_all[i] : exp_skip[i])) begin
                    n_fail++;
                    $display("FAIL rr_order_p%0d_g%0d: got %0d want %0d", phase, i, got[i],
                             phase == 0 ? exp_all[i] : exp_skip[i]);
                end
            end
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        int ok, n, wp, rp;
        start_txn(1, 1'b0, 22'h000010, 16'h0);
        wait_issue(ok);
        wait_ack(2, 1'b0, 16'h7777, n, wp, rp);
        bus.i_req[1] = 1'b0;
        start_txn(2, 1'b0, 22'h2AAAAA, 16'h0);
        wait_issue(ok);
        repeat (3) @(negedge clk);
        n_chk++; if (bus.o_busy !== 1'b1 || bus.o_rd_addr !== 22'h2AAAAA) begin
            n_fail++; $display("FAIL mid_pre: got %b/%h want 1/2aaaaa", bus.o_busy, bus.o_rd_addr); end
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_chk++; if ({bus.o_busy, bus.o_ack, bus.o_rd_req, bus.o_timeout} !== 7'b0) begin
            n_fail++; $display("FAIL mid_async_flags: got %b want 0", {bus.o_busy, bus.o_ack, bus.o_rd_req, bus.o_timeout}); end
        n_chk++; if ({bus.o_rd_addr, bus.o_wr_addr, bus.o_rdata} !== '0) begin
            n_fail++; $display("FAIL mid_async_data: got %h %h %h want 0", bus.o_rd_addr, bus.o_wr_addr, bus.o_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        ok = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_ack != '0 || bus.o_busy) ok = 1;
        end
        n_chk++; if (ok !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d want 0", ok); end
        start_txn(3, 1'b0, 22'h3FFFFF, 16'h0);
        start_txn(1, 1'b0, 22'h000011, 16'h0);
        wait_issue(ok);
        n_chk++; if ({ok[0], bus.o_rd_req} !== 2'b11 || bus.o_rd_addr !== 22'h000011) begin
            n_fail++; $display("FAIL mid_first_fit: got %b/%h want 11/000011", {ok[0], bus.o_rd_req}, bus.o_rd_addr); end
        bus.i_req[1] = 1'b0;
        wait_ack(1, 1'b0, 16'h0042, n, wp, rp);
        wait_issue(ok);
        n_chk++; if (bus.o_rd_addr !== 22'h3FFFFF) begin n_fail++; $display("FAIL mid_port3_addr: got %h want 3fffff", bus.o_rd_addr); end
        wait_ack(2, 1'b0, 16'h0001, n, wp, rp);
        bus.i_req[3] = 1'b0;
        n_chk++; if (n !== 4 || bus.o_ack !== 4'b1000 || bus.o_rdata !== 16'h0001) begin
            n_fail++; $display("FAIL mid_port3_ack: got %0d/%b/%h want 4/1000/0001", n, bus.o_ack, bus.o_rdata); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        apply_reset();
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_stray();
        test_round_robin();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
